cpu_multicycle_sequencer: RTL and testbench

- Multi-cycle FSM that sequences the single-issue CPU datapath: instruction fetch, decode, execute, data-memory access, multiply wait, writeback.
- Consumes the per-opcode control levels from the combinational control unit and turns them into one-cycle enables at the correct phase.
- Owns the instruction-memory and data-memory req/ack handshakes.
- Sits between the control unit and the PC, register file, HI/LO registers and memory ports.

---
 rtl/cpu_multicycle_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_multicycle_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_sequencer.sv
// cpu_multicycle_sequencer
// Multi-cycle control sequencer for the single-issue CPU datapath. Walks each
// instruction through FETCH, DECODE, EXEC, optional MEM or MULW, and WB.
// Per-opcode control levels from the control unit are latched in DECODE and
// turned into single-cycle enables in the phase where they take effect. This
// block owns the instruction-memory and data-memory req/ack handshakes.
// Optional build macro SEQ_PERF_CNT_EN adds the cycle_cnt and instr_cnt
// performance counters.
module cpu_multicycle_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter logic [4:0]  MUL_OPCODE = 5'b01101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [4:0]  opcode,
    input  logic        cu_reg_write,
    input  logic        cu_mem_read,
    input  logic        cu_mem_write,
    input  logic        cu_pc_jump,
    input  logic        cu_pc_branch,
    output logic        instr_req,
    input  logic        instr_ack,
    output logic        ir_load,
    output logic        data_req,
    output logic        data_we,
    input  logic        data_ack,
    output logic        rf_we,
    output logic        hilo_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [2:0]  state,
    output logic        busy
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        MULW   = 3'd5,
        WB     = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    // The MULW counter counts down to zero, so a load of MUL_CYCLES-1
    // gives exactly MUL_CYCLES cycles in MULW.
    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic       regWrite_q, regWrite_d;
    logic       memRead_q, memRead_d;
    logic       memWrite_q, memWrite_d;
    logic       jump_q, jump_d;
    logic       mulOp_q, mulOp_d;
    logic       pcTaken_q, pcTaken_d;
    logic [3:0] mulCnt_q, mulCnt_d;

    // State register and latched per-instruction controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            regWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            jump_q     <= 1'b0;
            mulOp_q    <= 1'b0;
            pcTaken_q  <= 1'b0;
            mulCnt_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            regWrite_q <= regWrite_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            jump_q     <= jump_d;
            mulOp_q    <= mulOp_d;
            pcTaken_q  <= pcTaken_d;
            mulCnt_q   <= mulCnt_d;
        end
    end

    // Next-state logic and phase-decoded strobes; everything is forced low
    // while reset is held so abandoned memory requests drop at once.
    always_comb begin
        state_d    = state_q;
        regWrite_d = regWrite_q;
        memRead_d  = memRead_q;
        memWrite_d = memWrite_q;
        jump_d     = jump_q;
        mulOp_d    = mulOp_q;
        pcTaken_d  = pcTaken_q;
        mulCnt_d   = mulCnt_q;
        instr_req  = 1'b0;
        ir_load    = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        rf_we      = 1'b0;
        hilo_we    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                regWrite_d = cu_reg_write;
                memRead_d  = cu_mem_read;
                memWrite_d = cu_mem_write;
                jump_d     = cu_pc_jump;
                mulOp_d    = (opcode == MUL_OPCODE);
                state_d    = EXEC;
            end
            EXEC: begin
                pc_load   = jump_q | cu_pc_branch;
                pcTaken_d = jump_q | cu_pc_branch;
                if (mulOp_q) begin
                    state_d  = MULW;
                    mulCnt_d = MulLoad;
                end else if (memRead_q | memWrite_q) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                data_req = 1'b1;
                data_we  = memWrite_q;
                if (data_ack) begin
                    state_d = WB;
                end
            end
            MULW: begin
                if (mulCnt_q == 4'd0) begin
                    hilo_we = 1'b1;
                    state_d = WB;
                end else begin
                    mulCnt_d = mulCnt_q - 4'd1;
                end
            end
            WB: begin
                rf_we     = regWrite_q & ~mulOp_q;
                pc_inc    = ~pcTaken_q;
                pcTaken_d = 1'b0;
                state_d   = run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            instr_req = 1'b0;
            ir_load   = 1'b0;
            data_req  = 1'b0;
            data_we   = 1'b0;
            rf_we     = 1'b0;
            hilo_we   = 1'b0;
            pc_inc    = 1'b0;
            pc_load   = 1'b0;
        end
    end

    assign state = rst ? 3'd0 : state_q;
    assign busy  = ~rst & (state_q != IDLE);

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycleCnt_q;
    logic [31:0] instrCnt_q;

    // Busy-cycle and retired-instruction counters; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCnt_q <= 32'd0;
            instrCnt_q <= 32'd0;
        end else begin
            if (state_q != IDLE) begin
                cycleCnt_q <= cycleCnt_q + 32'd1;
            end
            if (state_q == WB) begin
                instrCnt_q <= instrCnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycleCnt_q;
    assign instr_cnt = instrCnt_q;
`endif

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Testbench for cpu_multicycle_sequencer. Each instruction is described at the
// transaction level (opcode, control levels, handshake delays) and expanded
// into an expected per-cycle trace from the sequencing rules; the DUT is then
// stepped through that trace while spurious acks and branch levels are driven
// in phases where they must be ignored.
module tb_cpu_multicycle_sequencer;

    localparam int         MulCycles = 4;
    localparam logic [4:0] MulOpcode = 5'b01101;

    // Bit positions of the packed strobe vector compared each cycle.
    localparam logic [8:0] oReq   = 9'h100;
    localparam logic [8:0] oIrl   = 9'h080;
    localparam logic [8:0] oDreq  = 9'h040;
    localparam logic [8:0] oDwe   = 9'h020;
    localparam logic [8:0] oRfwe  = 9'h010;
    localparam logic [8:0] oHilo  = 9'h008;
    localparam logic [8:0] oPcinc = 9'h004;
    localparam logic [8:0] oPcld  = 9'h002;
    localparam logic [8:0] oBusy  = 9'h001;

    logic clk = 1'b0;
    logic rst, run;
    logic [4:0] opcode;
    logic cuRegWrite, cuMemRead, cuMemWrite, cuPcJump, cuPcBranch;
    logic instrReq, instrAck, irLoad, dataReq, dataWe, dataAck;
    logic rfWe, hiloWe, pcInc, pcLoad, busy;
    logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycleCnt, instrCnt;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic [2:0] st;
        logic [8:0] outs;
        logic       iAck;
        logic       dAck;
        logic       br;
        logic       runIn;
    } cycle_t;

    cycle_t plan[$];
    bit     idleNow;
    int     instrNum = 0;
    int     expCycles = 0;
    int     expInstr  = 0;

    cpu_multicycle_sequencer #(
        .MUL_CYCLES(MulCycles),
        .MUL_OPCODE(MulOpcode)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .cu_reg_write(cuRegWrite),
        .cu_mem_read (cuMemRead),
        .cu_mem_write(cuMemWrite),
        .cu_pc_jump  (cuPcJump),
        .cu_pc_branch(cuPcBranch),
        .instr_req   (instrReq),
        .instr_ack   (instrAck),
        .ir_load     (irLoad),
        .data_req    (dataReq),
        .data_we     (dataWe),
        .data_ack    (dataAck),
        .rf_we       (rfWe),
        .hilo_we     (hiloWe),
        .pc_inc      (pcInc),
        .pc_load     (pcLoad),
        .state       (state),
        .busy        (busy)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycleCnt),
        .instr_cnt   (instrCnt)
`endif
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic logic [8:0] observedOuts();
        return {instrReq, irLoad, dataReq, dataWe, rfWe, hiloWe, pcInc, pcLoad, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void addCycle(input logic [2:0] st, input logic [8:0] outs,
                                     input logic iAck, input logic dAck,
                                     input logic br, input logic runIn);
        cycle_t c;
        c.st = st; c.outs = outs; c.iAck = iAck; c.dAck = dAck; c.br = br; c.runIn = runIn;
        plan.push_back(c);
    endfunction

    // Expands one instruction into its expected cycle trace and steps the DUT.
    task automatic applyStimulus(input logic [4:0] op, input logic rw, input logic mr,
                                 input logic mw, input logic jmp, input logic br,
                                 input int fetchWait, input int memWait,
                                 input logic runAfter);
        bit   isMul;
        bit   taken;
        logic [8:0] o;
        isMul = (op == MulOpcode);
        taken = jmp | br;
        plan.delete();
        if (idleNow)
            addCycle(3'd0, 9'h000, rnd(), rnd(), rnd(), 1'b1);
        for (int k = 0; k <= fetchWait; k++) begin
            o = oReq | oBusy | ((k == fetchWait) ? oIrl : 9'h000);
            addCycle(3'd1, o, (k == fetchWait), rnd(), rnd(), rnd());
        end
        addCycle(3'd2, oBusy, rnd(), rnd(), rnd(), rnd());
        addCycle(3'd3, oBusy | (taken ? oPcld : 9'h000), rnd(), rnd(), br, rnd());
        if (isMul) begin
            for (int k = 0; k < MulCycles; k++)
                addCycle(3'd5, oBusy | ((k == MulCycles - 1) ? oHilo : 9'h000),
                         rnd(), rnd(), rnd(), rnd());
        end else if (mr | mw) begin
            for (int k = 0; k <= memWait; k++)
                addCycle(3'd4, oBusy | oDreq | (mw ? oDwe : 9'h000),
                         rnd(), (k == memWait), rnd(), rnd());
        end
        o = oBusy | ((rw && !isMul) ? oRfwe : 9'h000) | (taken ? 9'h000 : oPcinc);
        addCycle(3'd6, o, rnd(), rnd(), rnd(), runAfter);

        opcode = op; cuRegWrite = rw; cuMemRead = mr; cuMemWrite = mw; cuPcJump = jmp;
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            instrAck = plan[k].iAck; dataAck = plan[k].dAck;
            cuPcBranch = plan[k].br; run = plan[k].runIn;
            #1;
`ifdef SEQ_PERF_CNT_EN
            checkOutput($sformatf("i%0d c%0d cycle_cnt", instrNum, k), cycleCnt, expCycles);
            checkOutput($sformatf("i%0d c%0d instr_cnt", instrNum, k), instrCnt, expInstr);
`endif
            checkOutput($sformatf("i%0d c%0d state", instrNum, k), 32'(state), 32'(plan[k].st));
            checkOutput($sformatf("i%0d c%0d strobes", instrNum, k),
                        32'(observedOuts()), 32'(plan[k].outs));
            if (plan[k].st != 3'd0) expCycles++;
            if (plan[k].st == 3'd6) expInstr++;
        end
        idleNow = !runAfter;
        instrNum++;
    endtask

    // Random instruction mix: ALU, load, store, mul, branch/jump/NOP.
    task automatic randomInstr(input logic runAfter);
        logic [4:0] op;
        int kind;
        do op = 5'($urandom); while (op == MulOpcode);
        kind = $urandom_range(0, 4);
        case (kind)
            0: applyStimulus(op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 3), 0, runAfter);
            1: applyStimulus(op, 1'b1, 1'b1, 1'b0, 1'b0, rnd(), $urandom_range(0, 3),
                             $urandom_range(0, 4), runAfter);
            2: applyStimulus(op, 1'b0, rnd(), 1'b1, 1'b0, rnd(), $urandom_range(0, 3),
                             $urandom_range(0, 4), runAfter);
            3: applyStimulus(MulOpcode, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 3),
                             0, runAfter);
            default: applyStimulus(op, rnd(), 1'b0, 1'b0, rnd(), rnd(), $urandom_range(0, 3),
                                   0, runAfter);
        endcase
    endtask

    // Drives a load into MEM and asserts reset mid-access.
    task automatic resetInMem();
        bit reached;
        reached = 1'b0;
        @(negedge clk);
        run = 1'b1; opcode = 5'b00111; cuRegWrite = 1'b1; cuMemRead = 1'b1;
        cuMemWrite = 1'b0; cuPcJump = 1'b0; cuPcBranch = 1'b0;
        instrAck = 1'b1; dataAck = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (state == 3'd4) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("reached MEM", 32'(reached), 32'd1);
        checkOutput("data_req in MEM", 32'(dataReq), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst data_req", 32'(dataReq), 32'd0);
        checkOutput("async rst state", 32'(state), 32'd0);
        checkOutput("async rst strobes", 32'(observedOuts()), 32'd0);
        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("post rst state", 32'(state), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("post rst cycle_cnt", cycleCnt, 32'd0);
        checkOutput("post rst instr_cnt", instrCnt, 32'd0);
`endif
        expCycles = 0;
        expInstr  = 0;
        idleNow   = 1'b1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 5'd0;
        cuRegWrite = 1'b0; cuMemRead = 1'b0; cuMemWrite = 1'b0;
        cuPcJump = 1'b0; cuPcBranch = 1'b0; instrAck = 1'b0; dataAck = 1'b0;
        #3;
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset strobes", 32'(observedOuts()), 32'd0);
        run = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset held with run", 32'(state), 32'd0);
        checkOutput("reset held strobes", 32'(observedOuts()), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("reset cycle_cnt", cycleCnt, 32'd0);
        checkOutput("reset instr_cnt", instrCnt, 32'd0);
`endif
        run = 1'b0;
        rst = 1'b0;
        idleNow = 1'b1;

        // Three back-to-back ALU ops with a one-cycle fetch wait (5 cycles each).
        applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1);
        applyStimulus(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1);
        applyStimulus(5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
`ifdef SEQ_PERF_CNT_EN
        @(negedge clk);
        #1;
        checkOutput("three ALU cycle_cnt", cycleCnt, 32'd15);
        checkOutput("three ALU instr_cnt", instrCnt, 32'd3);
`endif
        // Load with data_ack three cycles late, mul, branch taken / not taken, NOP.
        applyStimulus(5'b00111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3, 1'b1);
        applyStimulus(MulOpcode, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1);
        applyStimulus(5'b01011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        applyStimulus(5'b01011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        applyStimulus(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        applyStimulus(5'b10001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);

        for (int n = 0; n < 40; n++)
            randomInstr((n == 39) ? 1'b0 : rnd());

        // Returned to IDLE after run dropped at WB.
        @(negedge clk);
        run = 1'b0;
        #1;
        checkOutput("final idle state", 32'(state), 32'd0);
        checkOutput("final idle busy", 32'(busy), 32'd0);

        resetInMem();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
